// File: rtl/f_calc_pkg.sv
// Shared types and sizing for the frequency/field calculators.
// Widths follow the worst-case products of 32-bit coefficients and an 8-bit harmonic.
package f_calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    MUL2,
    CHECK,
    DIV,
    SQRT,
    DONE
  } state_t;

  localparam int NUM_W     = 128;
  localparam int DEN_W     = 97;
  localparam int ROOT_W    = 64;
  localparam int DIV_ITER  = 128;
  localparam int SQRT_ITER = 64;

endpackage

// File: rtl/f_to_b_if.sv
// Request/result bundle for the F->B calculator.
interface f_to_b_if;

  logic        start;
  logic [31:0] freq;
  logic [31:0] a_coeff;
  logic [31:0] b_coeff;
  logic [31:0] c_coeff;
  logic [7:0]  k_coeff;
  logic [31:0] b_field;
  logic        ready;
  logic        busy;
  logic        err;
  logic        sat;

  modport master (
    output start, freq, a_coeff, b_coeff, c_coeff, k_coeff,
    input  b_field, ready, busy, err, sat
  );

  modport slave (
    input  start, freq, a_coeff, b_coeff, c_coeff, k_coeff,
    output b_field, ready, busy, err, sat
  );

endinterface

// File: rtl/f_to_b_isqrt_seq.sv
// Digit-by-digit binary integer square root, one root bit per cycle.
// The start edge already performs the first step, so done is high exactly SQRT_ITER cycles after start.
module isqrt_seq
  import f_calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  radicand,
  output logic [ROOT_W-1:0] root,
  output logic              done
);

  logic [NUM_W-1:0]  rad_q;
  logic [ROOT_W+1:0] rem_q;
  logic [ROOT_W-1:0] root_q;
  logic [6:0]        cnt_q;
  logic              running_q;

  logic [NUM_W-1:0]  src_rad;
  logic [ROOT_W+1:0] src_rem;
  logic [ROOT_W-1:0] src_root;
  logic [ROOT_W+3:0] rem_t;
  logic [ROOT_W+3:0] trial;
  logic              ge;
  logic [ROOT_W+1:0] rem_n;

  // A start overrides any state so the step reads the fresh radicand with zero partials.
  always_comb begin
    src_rad  = start ? radicand : rad_q;
    src_rem  = start ? '0 : rem_q;
    src_root = start ? '0 : root_q;
    rem_t    = {src_rem, src_rad[NUM_W-1:NUM_W-2]};
    trial    = {2'b00, src_root, 2'b01};
    ge       = (rem_t >= trial);
    rem_n    = ge ? (ROOT_W+2)'(rem_t - trial) : rem_t[ROOT_W+1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (start || (running_q && cnt_q != 7'(SQRT_ITER))) begin
      rad_q     <= {src_rad[NUM_W-3:0], 2'b00};
      rem_q     <= rem_n;
      root_q    <= {src_root[ROOT_W-2:0], ge};
      cnt_q     <= start ? 7'd1 : cnt_q + 7'd1;
      running_q <= 1'b1;
    end else if (running_q) begin
      running_q <= 1'b0;
    end
  end

  assign root = root_q;
  assign done = running_q && (cnt_q == 7'(SQRT_ITER));

endmodule

// File: rtl/f_to_b.sv
// Inverse ring-frequency calculator: B = f*sqrt(b) / sqrt((k*a)^2 - c*f^2).
// Evaluated as floor(sqrt(floor(b*f^2*4^FRAC_BITS / D))) with a serial divide then a serial root.
module f_to_b
  import f_calc_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input logic     clk,
  input logic     reset,
  f_to_b_if.slave bus
);

  state_t state_q, state_d;

  logic [7:0]       k_q;
  logic [31:0]      a_q, b_q, c_q, f_q;
  logic [39:0]      ka_q;
  logic [63:0]      f2_q;
  logic [79:0]      ka2_q;
  logic [95:0]      cf2_q;
  logic [NUM_W-1:0] div_q;
  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic [7:0]       cnt_q;
  logic [31:0]      b_field_q;
  logic             err_q, sat_q;

  logic [DEN_W-1:0] diff;
  logic             den_ok;
  logic [DEN_W:0]   rem_sh;
  logic             fits;
  logic [DEN_W-1:0] rem_next;
  logic [NUM_W-1:0] q_next;
  logic             div_last;
  logic [ROOT_W-1:0] sqrt_root;
  logic             sqrt_done;
  logic             root_big;

  // div_q holds the dividend and collects quotient bits from the right as it shifts.
  always_comb begin
    diff     = {17'd0, ka2_q} - {1'b0, cf2_q};
    den_ok   = !diff[DEN_W-1] && (diff != '0);
    rem_sh   = {rem_q, div_q[NUM_W-1]};
    fits     = (rem_sh >= {1'b0, den_q});
    rem_next = fits ? DEN_W'(rem_sh - {1'b0, den_q}) : rem_sh[DEN_W-1:0];
    q_next   = {div_q[NUM_W-2:0], fits};
    div_last = (state_q == DIV) && (cnt_q == 8'(DIV_ITER - 1));
    root_big = |sqrt_root[ROOT_W-1:32];
  end

  // The root engine is launched on the final divide edge with the quotient as it is being formed.
  isqrt_seq u_isqrt (
    .clk      (clk),
    .reset    (reset),
    .start    (div_last),
    .radicand (q_next),
    .root     (sqrt_root),
    .done     (sqrt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MUL1;
      MUL1:    state_d = MUL2;
      MUL2:    state_d = CHECK;
      CHECK:   state_d = den_ok ? DIV : DONE;
      DIV:     if (div_last) state_d = SQRT;
      SQRT:    if (sqrt_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q <= '0; a_q <= '0; b_q <= '0; c_q <= '0; f_q <= '0;
      ka_q <= '0; f2_q <= '0; ka2_q <= '0; cf2_q <= '0;
      div_q <= '0; rem_q <= '0; den_q <= '0; cnt_q <= '0;
      b_field_q <= '0; err_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          k_q <= bus.k_coeff;
          a_q <= bus.a_coeff;
          b_q <= bus.b_coeff;
          c_q <= bus.c_coeff;
          f_q <= bus.freq;
        end
        MUL1: begin
          ka_q <= 40'(k_q) * 40'(a_q);
          f2_q <= 64'(f_q) * 64'(f_q);
        end
        MUL2: begin
          ka2_q <= 80'(ka_q) * 80'(ka_q);
          cf2_q <= 96'(c_q) * 96'(f2_q);
          div_q <= (NUM_W'(b_q) * NUM_W'(f2_q)) << (2 * FRAC_BITS);
        end
        CHECK: begin
          den_q <= diff;
          rem_q <= '0;
          cnt_q <= '0;
          if (!den_ok) begin
            b_field_q <= '0;
            err_q     <= 1'b1;
            sat_q     <= 1'b0;
          end
        end
        DIV: begin
          div_q <= q_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 8'd1;
        end
        SQRT: if (sqrt_done) begin
          b_field_q <= root_big ? 32'hFFFF_FFFF : sqrt_root[31:0];
          err_q     <= 1'b0;
          sat_q     <= root_big;
        end
        default: ;
      endcase
    end
  end

  assign bus.b_field = b_field_q;
  assign bus.err     = err_q;
  assign bus.sat     = sat_q;
  assign bus.ready   = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_f_to_b.sv
// Self-checking bench for f_to_b: two instances (FRAC_BITS 0 and 4) against an exact arithmetic model.
module tb_f_to_b;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] last_bf0;

  f_to_b_if bus0();
  f_to_b_if bus4();

  f_to_b #(.FRAC_BITS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  f_to_b #(.FRAC_BITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Exact closed form: wide integer arithmetic, real division, root found by bisection on r*r <= q.
  task automatic ref_model(input logic [7:0] k, input logic [31:0] a, b, c, f, input int frac,
                           output logic [31:0] bf, output logic e, output logic s);
    logic [129:0] ka2, cf2, num, q, lo, hi, mid;
    ka2 = (130'(k) * 130'(a)) * (130'(k) * 130'(a));
    cf2 = 130'(c) * 130'(f) * 130'(f);
    e = 1'b0; s = 1'b0; bf = '0;
    if (cf2 >= ka2) begin
      e = 1'b1;
    end else begin
      num = (130'(b) * 130'(f) * 130'(f)) << (2 * frac);
      q   = num / (ka2 - cf2);
      lo  = '0;
      hi  = 130'(1) << 65;
      while (hi - lo > 1) begin
        mid = (lo + hi) >> 1;
        if (mid * mid <= q) lo = mid;
        else                hi = mid;
      end
      if (lo >= (130'(1) << 32)) begin
        s  = 1'b1;
        bf = 32'hFFFF_FFFF;
      end else begin
        bf = lo[31:0];
      end
    end
  endtask

  task automatic set_inputs(input logic [7:0] k, input logic [31:0] a, b, c, f);
    bus0.k_coeff = k; bus0.a_coeff = a; bus0.b_coeff = b; bus0.c_coeff = c; bus0.freq = f;
    bus4.k_coeff = k; bus4.a_coeff = a; bus4.b_coeff = b; bus4.c_coeff = c; bus4.freq = f;
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] k, input logic [31:0] a, b, c, f);
    logic [31:0] ebf0, ebf4, gbf0, gbf4;
    logic        ee0, es0, ee4, es4, ge0, gs0, ge4, gs4;
    int          exp_lat, lat0, lat4, cyc;
    ref_model(k, a, b, c, f, 0, ebf0, ee0, es0);
    ref_model(k, a, b, c, f, 4, ebf4, ee4, es4);
    exp_lat = ee0 ? 4 : 196;
    lat0 = -1; lat4 = -1;
    gbf0 = '0; gbf4 = '0; ge0 = 0; gs0 = 0; ge4 = 0; gs4 = 0;
    @(negedge clk);
    set_inputs(k, a, b, c, f);
    bus0.start = 1'b1; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0; bus4.start = 1'b0;
    set_inputs(8'($urandom), $urandom, $urandom, $urandom, $urandom);
    cyc = 1;
    while ((lat0 < 0 || lat4 < 0) && cyc < 260) begin
      if (bus0.ready && lat0 < 0) begin
        lat0 = cyc; gbf0 = bus0.b_field; ge0 = bus0.err; gs0 = bus0.sat;
      end
      if (bus4.ready && lat4 < 0) begin
        lat4 = cyc; gbf4 = bus4.b_field; ge4 = bus4.err; gs4 = bus4.sat;
      end
      if (lat0 < 0 || lat4 < 0) begin
        @(posedge clk); #1; cyc++;
      end
    end
    check_output({tag, " latency0"}, 64'(lat0), 64'(exp_lat));
    check_output({tag, " latency4"}, 64'(lat4), 64'(exp_lat));
    check_output({tag, " b_field0"}, 64'(gbf0), 64'(ebf0));
    check_output({tag, " err/sat0"}, {62'd0, ge0, gs0}, {62'd0, ee0, es0});
    check_output({tag, " b_field4"}, 64'(gbf4), 64'(ebf4));
    check_output({tag, " err/sat4"}, {62'd0, ge4, gs4}, {62'd0, ee4, es4});
    @(posedge clk); #1;
    check_output({tag, " post ready/busy"}, {60'd0, bus0.ready, bus0.busy, bus4.ready, bus4.busy}, 64'd0);
    check_output({tag, " hold b_field0"}, 64'(bus0.b_field), 64'(ebf0));
    last_bf0 = ebf0;
  endtask

  initial begin
    int          cyc, nready, lat;
    logic [31:0] rb, ra, rc, rf;
    logic [7:0]  rk;
    reset = 1'b1;
    bus0.start = 1'b0; bus4.start = 1'b0;
    set_inputs('0, '0, '0, '0, '0);
    last_bf0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset outputs0", {27'd0, bus0.b_field, bus0.err, bus0.sat, bus0.ready, bus0.busy}, 64'd0);
    check_output("reset outputs4", {27'd0, bus4.b_field, bus4.err, bus4.sat, bus4.ready, bus4.busy}, 64'd0);
    @(negedge clk); reset = 1'b0;

    apply_stimulus("basic",    8'd1, 32'd5,    32'd9,  32'd16, 32'd1);
    apply_stimulus("c0 r4",    8'd1, 32'd3,    32'd16, 32'd0,  32'd3);
    apply_stimulus("c0 r5",    8'd1, 32'd1000, 32'd1,  32'd0,  32'd5000);
    apply_stimulus("D zero",   8'd1, 32'd5,    32'd9,  32'd25, 32'd1);
    apply_stimulus("D neg",    8'd1, 32'd5,    32'd9,  32'd16, 32'd2);
    apply_stimulus("saturate", 8'd1, 32'd1,    32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    apply_stimulus("f zero",   8'd7, 32'd123,  32'd55, 32'd9,  32'd0);
    apply_stimulus("b zero",   8'd2, 32'd40,   32'd0,  32'd3,  32'd17);
    apply_stimulus("k zero",   8'd0, 32'd40,   32'd5,  32'd3,  32'd17);

    for (int i = 0; i < 20; i++) begin
      rk = 8'($urandom);
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      rc = $urandom >> $urandom_range(0, 31);
      rf = $urandom >> $urandom_range(0, 31);
      apply_stimulus($sformatf("rand%0d", i), rk, ra, rb, rc, rf);
    end

    // Extra starts while busy and one in the DONE cycle must all be dropped.
    @(negedge clk);
    set_inputs(8'd1, 32'd5, 32'd9, 32'd16, 32'd1);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    cyc = 1; nready = 0; lat = -1;
    while (cyc < 230) begin
      if (bus0.ready) begin
        nready++;
        if (lat < 0) begin
          lat = cyc;
          check_output("ignore b_field", 64'(bus0.b_field), 64'd1);
        end
      end
      if (cyc == 10) check_output("hold during busy", 64'(bus0.b_field), 64'(last_bf0));
      if (lat > 0 && cyc == lat + 1) check_output("start in DONE ignored", 64'(bus0.busy), 64'd0);
      bus0.start = (cyc == 10 || cyc == 50 || cyc == lat);
      if (bus0.start) set_inputs(8'd1, 32'd3, 32'd16, 32'd0, 32'd3);
      @(posedge clk); #1; cyc++;
    end
    bus0.start = 1'b0;
    check_output("ignore ready count", 64'(nready), 64'd1);
    check_output("ignore latency", 64'(lat), 64'd196);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    set_inputs(8'd1, 32'd3, 32'd16, 32'd0, 32'd3);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("midop reset outputs", {27'd0, bus0.b_field, bus0.err, bus0.sat, bus0.ready, bus0.busy}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    nready = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (bus0.ready || bus0.busy) nready++;
    end
    check_output("no ready after reset", 64'(nready), 64'd0);
    apply_stimulus("after reset", 8'd1, 32'd3, 32'd16, 32'd0, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
